// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the breadboard CPU control path: control-word bit
// positions, opcode encodings and microstep geometry.
package control_sequencer_pkg;

  localparam int unsigned OPW   = 4;
  localparam int unsigned STEPS = 5;
  localparam int unsigned STEPW = 3;
  localparam int unsigned CTRLW = 16;

  localparam int unsigned B_HLT = 15;
  localparam int unsigned B_MI  = 14;
  localparam int unsigned B_RI  = 13;
  localparam int unsigned B_RO  = 12;
  localparam int unsigned B_IO  = 11;
  localparam int unsigned B_II  = 10;
  localparam int unsigned B_AI  = 9;
  localparam int unsigned B_AO  = 8;
  localparam int unsigned B_EO  = 7;
  localparam int unsigned B_SU  = 6;
  localparam int unsigned B_BI  = 5;
  localparam int unsigned B_OI  = 4;
  localparam int unsigned B_CE  = 3;
  localparam int unsigned B_CO  = 2;
  localparam int unsigned B_J   = 1;
  localparam int unsigned B_FI  = 0;

  localparam logic [CTRLW-1:0] C_HLT = CTRLW'(1) << B_HLT;
  localparam logic [CTRLW-1:0] C_MI  = CTRLW'(1) << B_MI;
  localparam logic [CTRLW-1:0] C_RI  = CTRLW'(1) << B_RI;
  localparam logic [CTRLW-1:0] C_RO  = CTRLW'(1) << B_RO;
  localparam logic [CTRLW-1:0] C_IO  = CTRLW'(1) << B_IO;
  localparam logic [CTRLW-1:0] C_II  = CTRLW'(1) << B_II;
  localparam logic [CTRLW-1:0] C_AI  = CTRLW'(1) << B_AI;
  localparam logic [CTRLW-1:0] C_AO  = CTRLW'(1) << B_AO;
  localparam logic [CTRLW-1:0] C_EO  = CTRLW'(1) << B_EO;
  localparam logic [CTRLW-1:0] C_SU  = CTRLW'(1) << B_SU;
  localparam logic [CTRLW-1:0] C_BI  = CTRLW'(1) << B_BI;
  localparam logic [CTRLW-1:0] C_OI  = CTRLW'(1) << B_OI;
  localparam logic [CTRLW-1:0] C_CE  = CTRLW'(1) << B_CE;
  localparam logic [CTRLW-1:0] C_CO  = CTRLW'(1) << B_CO;
  localparam logic [CTRLW-1:0] C_J   = CTRLW'(1) << B_J;
  localparam logic [CTRLW-1:0] C_FI  = CTRLW'(1) << B_FI;

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LDA = 4'h1;
  localparam logic [OPW-1:0] OP_ADD = 4'h2;
  localparam logic [OPW-1:0] OP_SUB = 4'h3;
  localparam logic [OPW-1:0] OP_STA = 4'h4;
  localparam logic [OPW-1:0] OP_LDI = 4'h5;
  localparam logic [OPW-1:0] OP_JMP = 4'h6;
  localparam logic [OPW-1:0] OP_JC  = 4'h7;
  localparam logic [OPW-1:0] OP_JZ  = 4'h8;
  localparam logic [OPW-1:0] OP_OUT = 4'hE;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } seq_state_t;

endpackage

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: {opcode, step, flags} -> raw control word.
// Fetch steps are common to all opcodes; unlisted execute steps decode to zero.
module microcode_rom
  import control_sequencer_pkg::*;
(
  input  logic [OPW-1:0]   opcode,
  input  logic [STEPW-1:0] step,
  input  logic             flag_c,
  input  logic             flag_z,
  output logic [CTRLW-1:0] ctrl_raw
);

  logic [CTRLW-1:0] t2, t3, t4;

  always_comb begin
    t2 = '0;
    t3 = '0;
    t4 = '0;
    case (opcode)
      OP_LDA: begin t2 = C_IO | C_MI; t3 = C_RO | C_AI; end
      OP_ADD: begin t2 = C_IO | C_MI; t3 = C_RO | C_BI; t4 = C_EO | C_AI | C_FI; end
      OP_SUB: begin t2 = C_IO | C_MI; t3 = C_RO | C_BI; t4 = C_EO | C_AI | C_SU | C_FI; end
      OP_STA: begin t2 = C_IO | C_MI; t3 = C_AO | C_RI; end
      OP_LDI: t2 = C_IO | C_AI;
      OP_JMP: t2 = C_IO | C_J;
      OP_JC:  t2 = flag_c ? (C_IO | C_J) : '0;
      OP_JZ:  t2 = flag_z ? (C_IO | C_J) : '0;
      OP_OUT: t2 = C_AO | C_OI;
      OP_HLT: t2 = C_HLT;
      default: ;
    endcase
  end

  always_comb begin
    case (step)
      3'd0:    ctrl_raw = C_CO | C_MI;
      3'd1:    ctrl_raw = C_RO | C_II | C_CE;
      3'd2:    ctrl_raw = t2;
      3'd3:    ctrl_raw = t3;
      3'd4:    ctrl_raw = t4;
      default: ctrl_raw = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: microstep counter, RUN/HALT state, early instruction
// end and reset/halt masking of the decoded control word.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic [OPW-1:0]   opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  output logic [CTRLW-1:0] ctrl,
  output logic [STEPW-1:0] step,
  output logic             halted
);

  localparam logic [STEPW-1:0] STEP_LAST = STEPW'(STEPS - 1);

  seq_state_t       state, state_nxt;
  logic [STEPW-1:0] step_nxt;
  logic [CTRLW-1:0] ctrl_raw;

  microcode_rom u_rom (
    .opcode   (opcode),
    .step     (step),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .ctrl_raw (ctrl_raw)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_RUN;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // An all-zero execute word means the instruction has nothing left to do.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    if (state == ST_RUN) begin
      if (ctrl_raw[B_HLT])
        state_nxt = ST_HALT;
      else if (step == STEP_LAST || (step >= 3'd2 && ctrl_raw == '0))
        step_nxt = '0;
      else
        step_nxt = step + 3'd1;
    end
  end

  // Reset gates ctrl asynchronously so no strobe can fire while clr_n is low.
  always_comb begin
    if (!clr_n)
      ctrl = '0;
    else if (state == ST_HALT)
      ctrl = C_HLT;
    else
      ctrl = ctrl_raw;
  end

  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes expected outputs from
// a per-instruction microprogram table; a negedge monitor pops and compares.
module tb_control_sequencer;

  localparam logic [15:0] W_HLT = 16'h8000, W_MI = 16'h4000, W_RI = 16'h2000,
                          W_RO  = 16'h1000, W_IO = 16'h0800, W_II = 16'h0400,
                          W_AI  = 16'h0200, W_AO = 16'h0100, W_EO = 16'h0080,
                          W_SU  = 16'h0040, W_BI = 16'h0020, W_OI = 16'h0010,
                          W_CE  = 16'h0008, W_CO = 16'h0004, W_J  = 16'h0002,
                          W_FI  = 16'h0001;
  localparam logic [15:0] BUS_DRIVERS = W_RO | W_IO | W_AO | W_EO | W_CO;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ctrl),
    .step   (step),
    .halted (halted)
  );

  typedef struct {
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_step = 0;
  bit   m_halt = 1'b0;

  // Reference microprogram: fetch words, then the execute words for each opcode.
  function automatic logic [15:0] micro(int op, int st, bit c, bit z);
    logic [15:0] prog[3];
    prog = '{16'h0, 16'h0, 16'h0};
    if (st == 0) return W_CO | W_MI;
    if (st == 1) return W_RO | W_II | W_CE;
    case (op)
      1:  prog = '{W_IO | W_MI, W_RO | W_AI, 16'h0};
      2:  prog = '{W_IO | W_MI, W_RO | W_BI, W_EO | W_AI | W_FI};
      3:  prog = '{W_IO | W_MI, W_RO | W_BI, W_EO | W_AI | W_SU | W_FI};
      4:  prog = '{W_IO | W_MI, W_AO | W_RI, 16'h0};
      5:  prog[0] = W_IO | W_AI;
      6:  prog[0] = W_IO | W_J;
      7:  if (c) prog[0] = W_IO | W_J;
      8:  if (z) prog[0] = W_IO | W_J;
      14: prog[0] = W_AO | W_OI;
      15: prog[0] = W_HLT;
      default: ;
    endcase
    return prog[st - 2];
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] req, int tag);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s tag=%0d t=%0t actual=%h required=%h", name, tag, $time, act, req);
    end
  endtask

  task automatic cycle(bit rst_release, int op, bit c, bit z, int tag);
    exp_t        e;
    logic [15:0] w;
    logic [3:0]  opv;
    @(posedge clk);
    #1;
    opv    = 4'(op);
    clr_n  = rst_release;
    opcode = opv;
    flag_c = c;
    flag_z = z;
    if (!rst_release) begin
      m_step = 0;
      m_halt = 1'b0;
      e = '{16'h0, 3'd0, 1'b0, tag};
    end else if (m_halt) begin
      e = '{W_HLT, 3'(m_step), 1'b1, tag};
    end else begin
      w = micro(op, m_step, c, z);
      e = '{w, 3'(m_step), 1'b0, tag};
      if ((w & W_HLT) != 16'h0) m_halt = 1'b1;
      else if (m_step == 4 || (m_step >= 2 && w == 16'h0)) m_step = 0;
      else m_step++;
    end
    sbq.push_back(e);
  endtask

  task automatic run_instr(int op, bit c, bit z, int tag);
    int n = 0;
    do begin
      cycle(1'b1, op, c, z, tag);
      n++;
    end while (m_step != 0 && !m_halt && n < 6);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("ctrl", ctrl, e.ctrl, e.tag);
        check("step", {13'h0, step}, {13'h0, e.step}, e.tag);
        check("halted", {15'h0, halted}, {15'h0, e.halted}, e.tag);
      end
      check("bus_onehot", 16'($countones(ctrl & BUS_DRIVERS) <= 1), 16'h1, -1);
    end
  end

  initial begin : stimulus
    bit rel;
    repeat (3) cycle(1'b0, 0, 1'b0, 1'b0, 1);
    run_instr(0, 1'b0, 1'b0, 2);
    run_instr(1, 1'b0, 1'b0, 3);
    run_instr(2, 1'b1, 1'b0, 4);
    run_instr(3, 1'b0, 1'b1, 5);
    run_instr(4, 1'b0, 1'b0, 6);
    run_instr(5, 1'b0, 1'b0, 7);
    run_instr(6, 1'b0, 1'b0, 8);
    run_instr(7, 1'b1, 1'b0, 9);
    run_instr(7, 1'b0, 1'b1, 10);
    run_instr(8, 1'b0, 1'b1, 11);
    run_instr(8, 1'b1, 1'b0, 12);
    run_instr(14, 1'b0, 1'b0, 13);
    run_instr(9, 1'b1, 1'b1, 14);
    run_instr(13, 1'b1, 1'b1, 15);

    // Halt: frozen for 20 clocks regardless of opcode, left only through clr_n.
    run_instr(15, 1'b0, 1'b0, 16);
    repeat (20) cycle(1'b1, int'($urandom_range(15)), 1'($urandom), 1'($urandom), 17);
    cycle(1'b0, 0, 1'b0, 1'b0, 18);
    run_instr(1, 1'b0, 1'b0, 19);

    // Asynchronous reset in the middle of ADD T3.
    repeat (4) cycle(1'b1, 2, 1'b0, 1'b0, 20);
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("async_ctrl", ctrl, 16'h0, 21);
    check("async_step", {13'h0, step}, 16'h0, 21);
    check("async_halted", {15'h0, halted}, 16'h0, 21);
    m_step = 0;
    m_halt = 1'b0;
    cycle(1'b0, 2, 1'b0, 1'b0, 22);
    run_instr(2, 1'b0, 1'b0, 23);

    repeat (1000) begin
      rel = !(m_halt || $urandom_range(63) == 0);
      cycle(rel, int'($urandom_range(15)), 1'($urandom), 1'($urandom), 24);
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drain", 16'(sbq.size()), 16'h0, 25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
